// File: rtl/issueq_freelist.sv
// issueq_freelist: circular free list of IQ entry IDs with multi-lane allocate/free,
// busy tracking for illegal-free detection, IQ-full stall and a sticky error flag.
module issueq_freelist #(
  parameter int SIZE_ISSUEQ = 32,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH = 5,
  localparam int L = $clog2(SIZE_ISSUEQ),
  localparam int W = L + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      dispatchReady_i,
  input  logic [ISSUE_WIDTH*W-1:0]    freedEntry_i,
  output logic [DISPATCH_WIDTH*W-1:0] freeEntry_o,
  output logic [L:0]                freeCount_o,
  output logic                      iqStall_o,
  output logic                      errorFlag_o
);
  localparam logic [L:0] DW = W'(DISPATCH_WIDTH);
  logic [L-1:0] list [SIZE_ISSUEQ];
  logic [L-1:0] head, tail;
  logic [L:0] count, nfree;
  logic [SIZE_ISSUEQ-1:0] busy, busy_n;
  logic err, alloc, bad;
  logic [ISSUE_WIDTH-1:0] fv, legal;
  logic [L-1:0] fid [ISSUE_WIDTH];
  logic [L-1:0] wpos [ISSUE_WIDTH];
  always_comb begin
    alloc = dispatchReady_i && count >= DW;
    legal = '0;
    nfree = '0;
    busy_n = busy;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      fv[i] = freedEntry_i[i*W+L];
      fid[i] = freedEntry_i[i*W +: L];
    end
    for (int k = 0; k < DISPATCH_WIDTH; k++)
      if (alloc) busy_n[list[head + L'(k)]] = 1'b1;
    // legal frees are compacted: each lands at tail plus the number of legal lanes before it
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      legal[i] = fv[i] && busy[fid[i]];
      for (int j = 0; j < i; j++)
        if (fv[j] && fid[j] == fid[i]) legal[i] = 1'b0;
      wpos[i] = tail + nfree[L-1:0];
      if (legal[i]) busy_n[fid[i]] = 1'b0;
      nfree = nfree + W'(legal[i]);
    end
    bad = (|(fv & ~legal)) || (dispatchReady_i && !alloc);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) list[i] <= L'(i);
      head <= '0;
      tail <= '0;
      count <= W'(SIZE_ISSUEQ);
      busy <= '0;
      err <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) list[i] <= L'(i);
      head <= '0;
      tail <= '0;
      count <= W'(SIZE_ISSUEQ);
      busy <= '0;
    end else begin
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (legal[i]) list[wpos[i]] <= fid[i];
      head <= alloc ? head + L'(DISPATCH_WIDTH) : head;
      tail <= tail + nfree[L-1:0];
      count <= count - (alloc ? DW : '0) + nfree;
      busy <= busy_n;
      err <= err | bad;
    end
  end
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_lane
    assign freeEntry_o[k*W +: W] = {count > W'(k), list[head + L'(k)]};
  end
  assign freeCount_o = count;
  assign iqStall_o = count < DW;
  assign errorFlag_o = err;
endmodule

// File: tb/tb_issueq_freelist.sv
// tb_issueq_freelist: queue-based reference model feeding a scoreboard of expected outputs.
module tb_issueq_freelist;
  typedef struct packed {
    logic [3:0]  v;
    logic [19:0] ids;
    logic [5:0]  cnt;
    logic        stall;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush_i = 1'b0;
  logic dispatchReady_i = 1'b0;
  logic [29:0] freedEntry_i = '0;
  logic [23:0] freeEntry_o;
  logic [5:0] freeCount_o;
  logic iqStall_o, errorFlag_o;
  int n_total = 0;
  int n_bad = 0;
  int fl[$];
  logic [31:0] mbusy;
  logic merr;
  exp_t sb[$];
  issueq_freelist dut (
    .clk(clk),
    .reset(reset),
    .flush_i(flush_i),
    .dispatchReady_i(dispatchReady_i),
    .freedEntry_i(freedEntry_i),
    .freeEntry_o(freeEntry_o),
    .freeCount_o(freeCount_o),
    .iqStall_o(iqStall_o),
    .errorFlag_o(errorFlag_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic logic [29:0] lane(input int k, input int id);
    logic [29:0] r = '0;
    r[k*6 +: 6] = {1'b1, 5'(id)};
    return r;
  endfunction
  function automatic int pb(input int n);
    int c = 0;
    for (int i = 0; i < 32; i++)
      if (mbusy[i]) begin
        if (c == n) return i;
        c++;
      end
    return -1;
  endfunction
  function automatic exp_t mk();
    exp_t e;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      e.v[k] = fl.size() > k;
      if (e.v[k]) e.ids[k*5 +: 5] = 5'(fl[k]);
    end
    e.cnt = 6'(fl.size());
    e.stall = fl.size() < 4;
    e.err = merr;
    return e;
  endfunction
  task automatic model_init();
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(i);
    mbusy = '0;
  endtask
  task automatic model(input bit d, input bit f, input logic [29:0] fr);
    logic [31:0] ob, seen;
    int id;
    if (f) begin
      model_init();
      return;
    end
    ob = mbusy;
    seen = '0;
    if (d) begin
      if (fl.size() >= 4)
        for (int k = 0; k < 4; k++) mbusy[fl.pop_front()] = 1'b1;
      else
        merr = 1'b1;
    end
    for (int i = 0; i < 5; i++)
      if (fr[i*6+5]) begin
        id = int'(fr[i*6 +: 5]);
        if (ob[id] && !seen[id]) begin
          seen[id] = 1'b1;
          fl.push_back(id);
          mbusy[id] = 1'b0;
        end else merr = 1'b1;
      end
  endtask
  task automatic cmp(input exp_t e);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), 32'(freeEntry_o[k*6+5]), 32'(e.v[k]));
      if (e.v[k]) chk($sformatf("id%0d", k), 32'(freeEntry_o[k*6 +: 5]), 32'(e.ids[k*5 +: 5]));
    end
    chk("count", 32'(freeCount_o), 32'(e.cnt));
    chk("stall", 32'(iqStall_o), 32'(e.stall));
    chk("err", 32'(errorFlag_o), 32'(e.err));
  endtask
  task automatic cyc(input bit d, input bit f, input logic [29:0] fr);
    dispatchReady_i = d;
    flush_i = f;
    freedEntry_i = fr;
    model(d, f, fr);
    sb.push_back(mk());
    @(posedge clk);
    #1;
    cmp(sb.pop_front());
    dispatchReady_i = 1'b0;
    flush_i = 1'b0;
    freedEntry_i = '0;
  endtask
  task automatic rst_pulse();
    #3 reset = 1'b0;
    model_init();
    merr = 1'b0;
    sb.push_back(mk());
    #1 cmp(sb.pop_front());
    #1 reset = 1'b1;
  endtask
  initial begin
    model_init();
    merr = 1'b0;
    #2 reset = 1'b0;
    sb.push_back(mk());
    #1 cmp(sb.pop_front());
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(0, 0, '0);
    for (int i = 0; i < 8; i++) cyc(1, 0, '0);
    cyc(0, 0, lane(0, 9) | lane(2, 3) | lane(4, 20));
    cyc(0, 0, lane(0, 5));
    cyc(1, 0, '0);
    cyc(0, 0, lane(0, pb(0)) | lane(1, pb(1)) | lane(2, pb(2)) | lane(3, pb(3)) | lane(4, pb(4)));
    cyc(0, 0, lane(0, pb(0)));
    cyc(1, 0, lane(1, pb(0)) | lane(3, pb(1)));
    cyc(0, 0, lane(0, fl[0]));
    cyc(0, 0, '0);
    rst_pulse();
    cyc(1, 0, '0);
    cyc(0, 0, lane(1, 2) | lane(2, 2));
    rst_pulse();
    for (int i = 0; i < 8; i++) cyc(1, 0, '0);
    cyc(0, 0, lane(0, 17) | lane(3, 30));
    cyc(1, 0, '0);
    rst_pulse();
    for (int n = 0; n < 300; n++) begin
      logic [29:0] fr = '0;
      bit d = (fl.size() >= 4) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 9) < 4) begin
          int id = (mbusy != 0 && $urandom_range(0, 7) != 0)
                   ? pb(int'($urandom_range(0, $countones(mbusy) - 1))) : int'($urandom_range(0, 31));
          fr |= lane(i, id);
        end
      cyc(d, 0, fr);
    end
    cyc(0, 1, '0);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0);
    cyc(0, 0, lane(0, pb(0)) | lane(1, pb(1)));
    cyc(1, 1, lane(0, pb(0)));
    cyc(0, 0, '0);
    cyc(1, 0, '0);
    rst_pulse();
    cyc(0, 0, '0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/issueq_freelist.md
# issueq_freelist

Circular free list of issue-queue entry IDs. It supplies the dispatch stage with `DISPATCH_WIDTH` free IQ slots per cycle, and it reclaims slots freed by the issue stage, up to `ISSUE_WIDTH` per cycle. It sits directly upstream of the age-ordering / IQ write logic: its `freeEntry_o` lanes are the `freeEntry_i` IDs those blocks use to index IQ entries. It also generates the IQ-full stall.

## Interface
- `SIZE_ISSUEQ`, 32: number of IQ entries; power of two.
- `DISPATCH_WIDTH`, 4: allocation lanes.
- `ISSUE_WIDTH`, 5: free lanes.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush_i` input 1: synchronous recovery; returns every entry to the free list.
- `dispatchReady_i` input 1: dispatch consumes all `DISPATCH_WIDTH` lanes this cycle.
- `freedEntry_i` input `[ISSUE_WIDTH]` x {valid 1, id log2(SIZE_ISSUEQ)}: entries released by issue.
- `freeEntry_o` output `[DISPATCH_WIDTH]` x {valid 1, id}: next free IDs, lane 0 oldest.
- `freeCount_o` output log2(SIZE_ISSUEQ)+1: entries currently on the list.
- `iqStall_o` output 1: `freeCount_o < DISPATCH_WIDTH`.
- `errorFlag_o` output 1: sticky; set on an illegal free or an illegal allocate.

## Operation
- State:
  - `list[SIZE_ISSUEQ]` of IDs.
  - `headPtr` and `tailPtr`, each log2(N) bits, wrapping modulo N.
  - `count`, log2(N)+1 bits.
  - `busy[SIZE_ISSUEQ]`: a set bit means the entry is allocated.
  - `err`.
- Reset / flush state: `list[i]=i`, head=tail=0, count=N, busy=0.
  - `err` is cleared by reset only. Flush does not clear it.
- Outputs:
  - `freeEntry_o[k].id = list[(headPtr+k) mod N]`.
  - `freeEntry_o[k].valid = (count > k)`.
  - All outputs are decoded combinationally from registered state only, with no input-to-output path.
- Allocate: when `dispatchReady_i` and `count >= DISPATCH_WIDTH`:
  - headPtr += `DISPATCH_WIDTH`.
  - Set `busy` for the `DISPATCH_WIDTH` popped IDs.
  - If `dispatchReady_i` arrives with `count < DISPATCH_WIDTH`: no pop, set `err`.
- Free:
  - A free lane is legal only if it is valid and `busy[id]=1`.
  - If the same ID appears on two lanes in one cycle, only the lowest such lane is legal.
  - Legal lanes are compacted in lane order and written at tail, tail+1, and so on. tailPtr advances by the number of legal lanes, and `busy[id]` is cleared for each.
  - Any illegal valid lane (not busy, or a duplicate) is dropped and sets `err`.
- Count: `count_next = count - (alloc ? DISPATCH_WIDTH : 0) + legalFrees`. The count can never exceed N because only busy entries are accepted.
- Simultaneous allocate and free in one cycle:
  - Both apply, and they touch disjoint list slots.
  - An ID freed in cycle t is not visible on `freeEntry_o` before t+1.
  - An ID allocated in cycle t may be freed in t+1 at the earliest.
- Flush has priority over allocate and free in the same cycle. The allocate and free are discarded and the list is reinitialised.
- Wrap-around: pointer arithmetic is modulo N. A multi-lane pop or push that spans index N-1 → 0 must be correct.

## Timing
- Allocate-to-output latency is 1 cycle: after a pop at edge t, lanes show the next IDs in t+1.
- Free-to-reuse latency is 1 cycle minimum, and only when the freed ID becomes one of the first `DISPATCH_WIDTH` list positions.
- `iqStall_o` reflects the registered count. Dispatch must not assert `dispatchReady_i` while `iqStall_o=1`; doing so is an `err` condition, not a hang.
- Reset values:
  - `freeEntry_o[k]` = {1,k}.
  - `freeCount_o` = N.
  - `iqStall_o` = 0.
  - `errorFlag_o` = 0.
- Reset asserted mid-operation restores these values immediately (asynchronously), regardless of the clock.

## Test plan
- **Reset, then idle:** expect lanes = IDs 0,1,2,3 all valid, count=32, stall=0, err=0.
- **Back-to-back allocates:** 8 consecutive `dispatchReady_i` cycles (N=32). The lanes step through 4..7, 8..11, … 28..31. After the 8th allocate, count=0, stall=1 and all lanes are invalid.
- **Free and wrap:** from the drained state, free IDs 9,3,20 on lanes 0,2,4 in one cycle. Next cycle count=3 and stall=1; lanes 0..2 show 9,3,20 and lane 3 is invalid. Free ID 5, then allocate: lanes are 9,3,20,5 and head wraps correctly.
- **Simultaneous allocate and free:** at count=6, allocate and free 2 IDs in one cycle. Next cycle count=4. The freed IDs appear only after the 2 remaining old entries.
- **Illegal operations:**
  - Free a non-busy ID: dropped, count unchanged, `errorFlag_o` stays 1 until reset.
  - Same ID on two lanes: accepted once, err=1.
  - Dispatch at count=2: no pop, err=1.
- **Flush, then async reset:** flush with 10 entries busy, concurrent with a free. Next cycle lanes = 0,1,2,3 and count=32. Reset pulsed low between clock edges: outputs return to reset values immediately.
